// File: rtl/delay_gen_pkg.sv
// Shared types and constants for the delay/pulse generator core.
// Holds the sequencer state encoding, default parameter values and the
// helper that turns a zero pulse width into a one-cycle width.
package delay_gen_pkg;

    localparam int unsigned DEF_N_CH    = 4;
    localparam int unsigned DEF_CNT_W   = 16;
    localparam int unsigned DEF_WID_W   = 8;
    localparam int unsigned DEF_BURST_W = 4;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    // A programmed width of 0 still yields a one-cycle pulse
    function automatic int unsigned width_or_one(input int unsigned w);
        return (w == 0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/delay_gen_channel.sv
// One delay/pulse channel: a cycle counter started on sequence entry, the
// window compare that drives the pulse, and the done flag.
//
// Ports:
//   clk_i      core clock
//   reset_i    synchronous active-high reset
//   enable_i   channel enabled for this sequence (shadow value)
//   delay_i    cycles from sequence start to pulse rise
//   width_i    pulse width in cycles (0 behaves as 1)
//   start_i    sequence entry: counter restarts at 0 this edge
//   run_i      sequence running: counter advances until done
//   clear_i    sequence abandoned or finished: drop output and done
//   out_o      registered pulse output
//   done_o     registered finished flag
module delay_gen_channel
    import delay_gen_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned WID_W = DEF_WID_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] delay_i,
    input  logic [WID_W-1:0] width_i,
    input  logic             start_i,
    input  logic             run_i,
    input  logic             clear_i,
    output logic             out_o,
    output logic             done_o
);

    // One extra bit so delay + width never wraps
    localparam int unsigned AW = CNT_W + 1;

    logic [AW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          done_q, done_d;
    logic [AW-1:0] lo_c;
    logic [AW-1:0] hi_c;

    // Pulse window is [lo, hi) in counter units
    assign lo_c = AW'(delay_i);
    assign hi_c = lo_c + AW'(width_or_one(32'(width_i)));

    // Next counter value; output and done are evaluated against it so the
    // registered flags line up with the counter they describe
    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out_q;
        done_d = done_q;
        if (clear_i) begin
            cnt_d  = '0;
            out_d  = 1'b0;
            done_d = 1'b0;
        end else if (start_i || run_i) begin
            if (start_i) begin
                cnt_d = '0;
            end else if (!done_q) begin
                cnt_d = cnt_q + AW'(1);
            end
            out_d  = enable_i && (cnt_d >= lo_c) && (cnt_d < hi_c);
            done_d = !enable_i || (cnt_d >= hi_c);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            out_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            done_q <= done_d;
        end
    end

    assign out_o  = out_q;
    assign done_o = done_q;

endmodule

// File: rtl/delay_gen_core.sv
// N-channel programmable delay/pulse generator. A start rising edge runs
// every enabled channel through delay then pulse; when all are done the core
// pulses main reset and rearms. Optional burst repeat with an idle gap is
// built only when DELAY_GEN_BURST_EN is defined; otherwise burst count and
// period inputs are ignored and each start yields one sequence.
//
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_start            synchronised start request, rising edge triggers
//   i_abort            level; returns a busy core to IDLE
//   i_cfg_load         strobe; copies configuration into shadows in IDLE
//   i_ch_enable        per-channel enable
//   i_delay, i_width   per-channel delay / pulse width, packed per channel
//   i_burst_count      sequences per start (0 behaves as 1)
//   i_period           idle cycles between burst sequences
//   o_ch_out           channel pulses
//   o_ch_done          per-channel finished flags for the current sequence
//   o_start_latch      high from accepted start until sequence end
//   o_main_reset       one-cycle pulse at sequence end or abort
//   o_busy             high outside IDLE
//   o_err_overrun      sticky; start edge seen while busy
module delay_gen_core
    import delay_gen_pkg::*;
#(
    parameter int unsigned N_CH    = DEF_N_CH,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned WID_W   = DEF_WID_W,
    parameter int unsigned BURST_W = DEF_BURST_W
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic                    i_cfg_load,
    input  logic [N_CH-1:0]         i_ch_enable,
    input  logic [N_CH*CNT_W-1:0]   i_delay,
    input  logic [N_CH*WID_W-1:0]   i_width,
    input  logic [BURST_W-1:0]      i_burst_count,
    input  logic [CNT_W-1:0]        i_period,
    output logic [N_CH-1:0]         o_ch_out,
    output logic [N_CH-1:0]         o_ch_done,
    output logic                    o_start_latch,
    output logic                    o_main_reset,
    output logic                    o_busy,
    output logic                    o_err_overrun
);

    state_e                  state_q, state_d;
    logic                    start_prev_q;
    logic                    start_latch_q, start_latch_d;
    logic                    main_reset_q, main_reset_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    logic [N_CH-1:0]         en_q, en_d;
    logic [N_CH*CNT_W-1:0]   delay_q, delay_d;
    logic [N_CH*WID_W-1:0]   width_q, width_d;

`ifdef DELAY_GEN_BURST_EN
    logic [BURST_W-1:0]      burst_cfg_q, burst_cfg_d;
    logic [BURST_W-1:0]      burst_left_q, burst_left_d;
    logic [CNT_W-1:0]        period_q, period_d;
    logic [CNT_W-1:0]        gap_cnt_q, gap_cnt_d;
`else
    logic                    unused_burst_cfg;
    assign unused_burst_cfg = ^{i_burst_count, i_period};
`endif

    logic                    start_edge_c;
    logic                    abort_c;
    logic                    cfg_take_c;
    logic                    ch_start_c;
    logic                    ch_run_c;
    logic                    ch_clear_c;
    logic [N_CH-1:0]         ch_out;
    logic [N_CH-1:0]         ch_done;

    assign start_edge_c = i_start && !start_prev_q;
    assign abort_c      = i_abort && (state_q != IDLE);
    assign cfg_take_c   = i_cfg_load && (state_q == IDLE);

    // Next-state, channel control and registered-output next values
    always_comb begin
        state_d       = state_q;
        ch_start_c    = 1'b0;
        ch_run_c      = 1'b0;
        ch_clear_c    = 1'b0;
        main_reset_d  = 1'b0;
        busy_d        = 1'b0;
        start_latch_d = 1'b0;
        err_d         = err_q;
        en_d          = en_q;
        delay_d       = delay_q;
        width_d       = width_q;
`ifdef DELAY_GEN_BURST_EN
        burst_cfg_d   = burst_cfg_q;
        burst_left_d  = burst_left_q;
        period_d      = period_q;
        gap_cnt_d     = gap_cnt_q;
`endif

        // Shadow configuration only changes while idle
        if (cfg_take_c) begin
            en_d    = i_ch_enable;
            delay_d = i_delay;
            width_d = i_width;
`ifdef DELAY_GEN_BURST_EN
            burst_cfg_d = i_burst_count;
            period_d    = i_period;
`endif
        end

        if (start_edge_c && (state_q != IDLE)) begin
            err_d = 1'b1;
        end else if (cfg_take_c) begin
            err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_edge_c && (|en_q)) begin
                    state_d    = RUN;
                    ch_start_c = 1'b1;
`ifdef DELAY_GEN_BURST_EN
                    burst_left_d = (burst_cfg_q == '0) ? BURST_W'(1) : burst_cfg_q;
`endif
                end
            end
            RUN: begin
                ch_run_c = 1'b1;
                if (&ch_done) begin
`ifdef DELAY_GEN_BURST_EN
                    if (burst_left_q > BURST_W'(1)) begin
                        burst_left_d = burst_left_q - BURST_W'(1);
                        // Zero period skips the gap and restarts at once
                        if (period_q == '0) begin
                            state_d    = RUN;
                            ch_start_c = 1'b1;
                        end else begin
                            state_d   = GAP;
                            gap_cnt_d = CNT_W'(1);
                        end
                    end else begin
                        state_d = DONE;
                    end
`else
                    state_d = DONE;
`endif
                end
            end
            GAP: begin
`ifdef DELAY_GEN_BURST_EN
                // gap_cnt holds the index of the current gap cycle
                if (gap_cnt_q >= period_q) begin
                    state_d    = RUN;
                    ch_start_c = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + CNT_W'(1);
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort_c) begin
            state_d    = IDLE;
            ch_start_c = 1'b0;
            ch_run_c   = 1'b0;
        end

        ch_clear_c    = (state_q != IDLE) && (state_d == IDLE);
        // DONE already pulses; an abort taken from DONE does not pulse again
        main_reset_d  = (state_d == DONE) || (abort_c && (state_q != DONE));
        busy_d        = (state_d != IDLE);
        start_latch_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= IDLE;
            start_prev_q  <= 1'b0;
            start_latch_q <= 1'b0;
            main_reset_q  <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            en_q          <= '0;
            delay_q       <= '0;
            width_q       <= '0;
`ifdef DELAY_GEN_BURST_EN
            burst_cfg_q   <= '0;
            burst_left_q  <= '0;
            period_q      <= '0;
            gap_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            start_prev_q  <= i_start;
            start_latch_q <= start_latch_d;
            main_reset_q  <= main_reset_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            en_q          <= en_d;
            delay_q       <= delay_d;
            width_q       <= width_d;
`ifdef DELAY_GEN_BURST_EN
            burst_cfg_q   <= burst_cfg_d;
            burst_left_q  <= burst_left_d;
            period_q      <= period_d;
            gap_cnt_q     <= gap_cnt_d;
`endif
        end
    end

    // Channel array
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        delay_gen_channel #(
            .CNT_W (CNT_W),
            .WID_W (WID_W)
        ) u_ch (
            .clk_i    (i_clk),
            .reset_i  (i_reset),
            .enable_i (en_q[g]),
            .delay_i  (delay_q[g*CNT_W +: CNT_W]),
            .width_i  (width_q[g*WID_W +: WID_W]),
            .start_i  (ch_start_c),
            .run_i    (ch_run_c),
            .clear_i  (ch_clear_c),
            .out_o    (ch_out[g]),
            .done_o   (ch_done[g])
        );
    end

    assign o_ch_out      = ch_out;
    assign o_ch_done     = ch_done;
    assign o_start_latch = start_latch_q;
    assign o_main_reset  = main_reset_q;
    assign o_busy        = busy_q;
    assign o_err_overrun = err_q;

endmodule

// File: tb/tb_delay_gen_core.sv
// Directed bench for delay_gen_core. Cycle numbers in the expectations are
// relative to k, the cycle in which i_start is first sampled high.
module tb_delay_gen_core;

    localparam int N_CH    = 4;
    localparam int CNT_W   = 16;
    localparam int WID_W   = 8;
    localparam int BURST_W = 4;

`ifdef DELAY_GEN_BURST_EN
    localparam int RST_T = 6;
`else
    localparam int RST_T = 2;
`endif

    logic                  clk = 1'b0;
    logic                  i_reset = 1'b1;
    logic                  i_start = 1'b0;
    logic                  i_abort = 1'b0;
    logic                  i_cfg_load = 1'b0;
    logic [N_CH-1:0]       i_ch_enable = '0;
    logic [N_CH*CNT_W-1:0] i_delay = '0;
    logic [N_CH*WID_W-1:0] i_width = '0;
    logic [BURST_W-1:0]    i_burst_count = '0;
    logic [CNT_W-1:0]      i_period = '0;
    logic [N_CH-1:0]       o_ch_out;
    logic [N_CH-1:0]       o_ch_done;
    logic                  o_start_latch;
    logic                  o_main_reset;
    logic                  o_busy;
    logic                  o_err_overrun;

    int checks = 0;
    int failures = 0;

    int first_hi[N_CH];
    int hi_cnt[N_CH];
    int done_at[N_CH];
    int rise_t[4];
    int rise_n, mr_cnt, mr_at, idle_at, busy_cnt;
    logic [N_CH-1:0] out_at_idle, done_at_idle;
    logic [11:0]     snap_rst;
    logic            prev0;

    always #5 clk = ~clk;

    delay_gen_core #(
        .N_CH    (N_CH),
        .CNT_W   (CNT_W),
        .WID_W   (WID_W),
        .BURST_W (BURST_W)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_cfg_load    (i_cfg_load),
        .i_ch_enable   (i_ch_enable),
        .i_delay       (i_delay),
        .i_width       (i_width),
        .i_burst_count (i_burst_count),
        .i_period      (i_period),
        .o_ch_out      (o_ch_out),
        .o_ch_done     (o_ch_done),
        .o_start_latch (o_start_latch),
        .o_main_reset  (o_main_reset),
        .o_busy        (o_busy),
        .o_err_overrun (o_err_overrun)
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_strobe();
        i_cfg_load = 1'b1;
        tick();
        i_cfg_load = 1'b0;
        tick();
    endtask

    task automatic set_cfg(input logic [3:0] en,
                           input logic [15:0] d0, input logic [15:0] d1,
                           input logic [15:0] d2, input logic [15:0] d3,
                           input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [7:0] w3,
                           input logic [3:0] burst, input logic [15:0] period,
                           input bit load);
        i_ch_enable   = en;
        i_delay       = {d3, d2, d1, d0};
        i_width       = {w3, w2, w1, w0};
        i_burst_count = burst;
        i_period      = period;
        if (load) cfg_strobe();
    endtask

    // Start a sequence and record per-cycle activity; optional abort, second
    // start edge, config strobe and reset at given relative cycles (0 = none)
    task automatic observe(input int abort_t, input int start2_t, input int cfg_t,
                           input int rst_t, input int max_cyc);
        for (int c = 0; c < N_CH; c++) begin
            first_hi[c] = -1; hi_cnt[c] = 0; done_at[c] = -1;
        end
        for (int r = 0; r < 4; r++) rise_t[r] = -1;
        rise_n = 0; mr_cnt = 0; mr_at = -1; idle_at = -1; busy_cnt = 0; prev0 = 1'b0;
        out_at_idle = '1; done_at_idle = '1; snap_rst = '1;
        i_start = 1'b1;
        for (int t = 1; t <= max_cyc; t++) begin
            tick();
            if (t == 1)            i_start = 1'b0;
            if (t == start2_t)     i_start = 1'b1;
            if (t == start2_t + 1) i_start = 1'b0;
            if (t == abort_t)      i_abort = 1'b1;
            if (t == abort_t + 1)  i_abort = 1'b0;
            if (t == cfg_t)        i_cfg_load = 1'b1;
            if (t == cfg_t + 1)    i_cfg_load = 1'b0;
            if (t == rst_t)        i_reset = 1'b1;
            if (t == rst_t + 1) begin
                snap_rst = {o_ch_out, o_ch_done, o_start_latch, o_main_reset, o_busy, o_err_overrun};
                i_reset  = 1'b0;
            end
            for (int c = 0; c < N_CH; c++) begin
                if (o_ch_out[c]) begin
                    if (first_hi[c] < 0) first_hi[c] = t;
                    hi_cnt[c]++;
                end
                if (o_ch_done[c] && done_at[c] < 0) done_at[c] = t;
            end
            if (o_ch_out[0] && !prev0) begin
                if (rise_n < 4) rise_t[rise_n] = t;
                rise_n++;
            end
            prev0 = o_ch_out[0];
            if (o_main_reset) begin mr_cnt++; mr_at = t; end
            if (o_busy) busy_cnt++;
            if (!o_busy && idle_at < 0) begin
                idle_at      = t;
                out_at_idle  = o_ch_out;
                done_at_idle = o_ch_done;
            end
            if (idle_at > 0 && t >= idle_at + 3 && t > start2_t + 1 && t > cfg_t + 1) break;
        end
        i_start = 1'b0; i_abort = 1'b0; i_cfg_load = 1'b0; i_reset = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        check_eq("reset_outs", {o_ch_out, o_ch_done, o_start_latch, o_main_reset, o_busy, o_err_overrun}, 0);
        i_reset = 1'b0;
        tick();

        // Single shot, all channels, mixed delays incl. max delay
        set_cfg(4'b1111, 16'd0, 16'd3, 16'd10, 16'd65535, 8'd1, 8'd0, 8'd5, 8'd255, 4'd0, 16'd0, 1'b1);
        observe(0, 0, 0, 0, 66000);
        check_eq("t1_ch0_first", first_hi[0], 1);
        check_eq("t1_ch0_cnt",   hi_cnt[0],   1);
        check_eq("t1_ch1_first", first_hi[1], 4);
        check_eq("t1_ch1_cnt",   hi_cnt[1],   1);
        check_eq("t1_ch2_first", first_hi[2], 11);
        check_eq("t1_ch2_cnt",   hi_cnt[2],   5);
        check_eq("t1_ch3_first", first_hi[3], 65536);
        check_eq("t1_ch3_cnt",   hi_cnt[3],   255);
        check_eq("t1_ch1_done",  done_at[1],  5);
        check_eq("t1_ch3_done",  done_at[3],  65791);
        check_eq("t1_mr_at",     mr_at,       65792);
        check_eq("t1_mr_cnt",    mr_cnt,      1);
        check_eq("t1_idle_at",   idle_at,     65793);

        // Channels 1 and 3 disabled
        set_cfg(4'b0101, 16'd0, 16'd3, 16'd10, 16'd65535, 8'd1, 8'd0, 8'd5, 8'd255, 4'd0, 16'd0, 1'b1);
        observe(0, 0, 0, 0, 100);
        check_eq("t2_ch1_cnt",   hi_cnt[1],   0);
        check_eq("t2_ch3_cnt",   hi_cnt[3],   0);
        check_eq("t2_ch2_first", first_hi[2], 11);
        check_eq("t2_ch3_done",  done_at[3],  1);
        check_eq("t2_mr_at",     mr_at,       17);
        check_eq("t2_mr_cnt",    mr_cnt,      1);

        // No channel enabled: start ignored
        set_cfg(4'b0000, 16'd0, 16'd3, 16'd10, 16'd20, 8'd1, 8'd0, 8'd5, 8'd2, 4'd0, 16'd0, 1'b1);
        observe(0, 0, 0, 0, 20);
        check_eq("t2_en0_busy", busy_cnt, 0);
        check_eq("t2_en0_mr",   mr_cnt,   0);

        // Overrun: second start edge during RUN
        set_cfg(4'b0001, 16'd5, 16'd0, 16'd0, 16'd0, 8'd2, 8'd0, 8'd0, 8'd0, 4'd0, 16'd0, 1'b1);
        observe(0, 3, 0, 0, 60);
        check_eq("t3_ch0_first", first_hi[0], 6);
        check_eq("t3_ch0_cnt",   hi_cnt[0],   2);
        check_eq("t3_mr_cnt",    mr_cnt,      1);
        check_eq("t3_err_set",   o_err_overrun, 1);
        cfg_strobe();
        check_eq("t3_err_clr",   o_err_overrun, 0);

        // Abort mid-RUN at k+5
        set_cfg(4'b1111, 16'd0, 16'd3, 16'd10, 16'd20, 8'd1, 8'd0, 8'd5, 8'd2, 4'd0, 16'd0, 1'b1);
        observe(5, 0, 0, 0, 60);
        check_eq("t4_idle_at",  idle_at,      6);
        check_eq("t4_mr_at",    mr_at,        6);
        check_eq("t4_mr_cnt",   mr_cnt,       1);
        check_eq("t4_ch2_cnt",  hi_cnt[2],    0);
        check_eq("t4_done_clr", done_at_idle, 0);
        check_eq("t4_out_clr",  out_at_idle,  0);

        // Burst of three, period 4, ch0 delay 2 width 1
        set_cfg(4'b0001, 16'd2, 16'd0, 16'd0, 16'd0, 8'd1, 8'd0, 8'd0, 8'd0, 4'd3, 16'd4, 1'b1);
        observe(0, 0, 0, 0, 80);
`ifdef DELAY_GEN_BURST_EN
        check_eq("t5_rises", rise_n,    3);
        check_eq("t5_rise0", rise_t[0], 3);
        check_eq("t5_rise1", rise_t[1], 11);
        check_eq("t5_rise2", rise_t[2], 19);
        check_eq("t5_mr_cnt", mr_cnt,   1);
        check_eq("t5_mr_at",  mr_at,    21);
`else
        check_eq("t5_rises",  rise_n,    1);
        check_eq("t5_rise0",  rise_t[0], 3);
        check_eq("t5_mr_cnt", mr_cnt,    1);
        check_eq("t5_mr_at",  mr_at,     5);
`endif

        // Reset mid-sequence (in GAP when bursts are built)
        observe(0, 0, 0, RST_T, 80);
        check_eq("t5_rst_outs", snap_rst, 0);

        // Config load while busy is ignored until an idle load
        set_cfg(4'b0001, 16'd4, 16'd0, 16'd0, 16'd0, 8'd1, 8'd0, 8'd0, 8'd0, 4'd0, 16'd0, 1'b1);
        set_cfg(4'b0001, 16'd7, 16'd0, 16'd0, 16'd0, 8'd1, 8'd0, 8'd0, 8'd0, 4'd0, 16'd0, 1'b0);
        observe(0, 0, 2, 0, 60);
        check_eq("t6_busy_load", first_hi[0], 5);
        observe(0, 0, 0, 0, 60);
        check_eq("t6_next_seq",  first_hi[0], 5);
        cfg_strobe();
        observe(0, 0, 0, 0, 60);
        check_eq("t6_idle_load", first_hi[0], 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
